// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller.
// Provides the FSM state enumeration, the state encoding width, the default
// data/address widths, and a small max helper for counter sizing.
package spi_pkg;

  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefAddrWidth = 7;
  localparam int unsigned StateW       = 3;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StGetAddr,
    StLatchAddr,
    StReadLoad,
    StReadShift,
    StWriteGet,
    StWriteCommit,
    StDone
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Handshake bundle between the SPI front end and the transfer controller.
// master: the front end (drives cs_cond, sclk_pos, sclk_neg, rw_bit).
// slave : the controller (drives addr_we, sr_load, dm_we, miso_en, busy and,
//         when SPI_XFER_ABORT_FLAG_EN is defined, abort).
interface spi_xfer_ctrl_if;

  logic cs_cond;   // conditioned chip select, active-low
  logic sclk_pos;  // one-cycle pulse on sclk rising edge
  logic sclk_neg;  // one-cycle pulse on sclk falling edge
  logic rw_bit;    // shift register bit 0, R/W flag (1 = read)
  logic addr_we;   // address latch enable
  logic sr_load;   // shift register parallel load
  logic dm_we;     // data memory write enable
  logic miso_en;   // MISO tristate enable
  logic busy;      // controller not idle
`ifdef SPI_XFER_ABORT_FLAG_EN
  logic abort;     // transfer cut short by chip select
`endif

  modport master (
    output cs_cond, sclk_pos, sclk_neg, rw_bit,
`ifdef SPI_XFER_ABORT_FLAG_EN
    input  abort,
`endif
    input  addr_we, sr_load, dm_we, miso_en, busy
  );

  modport slave (
    input  cs_cond, sclk_pos, sclk_neg, rw_bit,
`ifdef SPI_XFER_ABORT_FLAG_EN
    output abort,
`endif
    output addr_we, sr_load, dm_we, miso_en, busy
  );

endinterface

// File: rtl/spi_bitcount.sv
// Saturating bit counter for the SPI transfer controller.
// Ports: clk, rst_n (async active-low), clr (synchronous clear, wins over inc),
// inc (count one pulse), target (terminal count), last (high on the pulse that
// reaches target, so the FSM can move on the following cycle).
module spi_bitcount #(
  parameter int unsigned cnt_w = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [cnt_w-1:0] target,
  output logic             last
);

  logic [cnt_w-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != target)) begin
      // Stops at target rather than wrapping.
      count_d = count_q + cnt_w'(1);
    end
  end

  assign last = inc && (count_q == (target - cnt_w'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI slave transfer controller: sequences address capture, then either a
// read (load + shift out on MISO) or a write (shift in + commit to memory).
// Ports: clk, rst_n (async active-low), bus (spi_xfer_ctrl_if.slave).
// Optional feature: define SPI_XFER_ABORT_FLAG_EN to add bus.abort, a pulse
// for chip select rising while a transfer is still in progress.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned width     = DefWidth,
  parameter int unsigned addrwidth = DefAddrWidth
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_xfer_ctrl_if.slave bus
);

  // Wide enough for the address phase too when addrwidth+1 exceeds width.
  localparam int unsigned cnt_w = $clog2(max_u(width, addrwidth + 1) + 1);

  state_e           state_q, state_d;
  logic             armed_q;
  logic             cnt_inc, cnt_clr, cnt_last;
  logic [cnt_w-1:0] cnt_target;

  // A transfer may only start once chip select has been seen high after
  // reset, so a reset released mid-frame does not pick up a partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.cs_cond) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Only the pulse relevant to the current phase is counted.
  always_comb begin
    cnt_inc = 1'b0;
    case (state_q)
      StGetAddr, StWriteGet: cnt_inc = bus.sclk_pos;
      StReadShift:           cnt_inc = bus.sclk_neg;
      default:               cnt_inc = 1'b0;
    endcase
  end

  assign cnt_target = (state_q == StGetAddr) ? cnt_w'(addrwidth + 1) : cnt_w'(width);
  assign cnt_clr    = (state_d != state_q);

  spi_bitcount #(
    .cnt_w (cnt_w)
  ) u_bitcount (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .target (cnt_target),
    .last   (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:        if (!bus.cs_cond && armed_q) state_d = StGetAddr;
      StGetAddr:     if (cnt_last) state_d = StLatchAddr;
      StLatchAddr:   state_d = bus.rw_bit ? StReadLoad : StWriteGet;
      StReadLoad:    state_d = StReadShift;
      StReadShift:   if (cnt_last) state_d = StDone;
      StWriteGet:    if (cnt_last) state_d = StWriteCommit;
      StWriteCommit: state_d = StDone;
      StDone:        state_d = StDone;
      default:       state_d = StIdle;
    endcase
    // Chip select release overrides any pending phase transition.
    if (bus.cs_cond && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  // Strobes are suppressed in the cycle chip select is seen high.
  assign bus.addr_we = (state_q == StLatchAddr)   && !bus.cs_cond;
  assign bus.sr_load = (state_q == StReadLoad)    && !bus.cs_cond;
  assign bus.dm_we   = (state_q == StWriteCommit) && !bus.cs_cond;
  assign bus.miso_en = (state_q == StReadLoad) || (state_q == StReadShift);
  assign bus.busy    = (state_q != StIdle);

`ifdef SPI_XFER_ABORT_FLAG_EN
  assign bus.abort = bus.cs_cond && (state_q != StIdle) && (state_q != StDone);
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed, table-driven bench for spi_xfer_ctrl: read, back-to-back write,
// DONE hold, plus hand-written abort, strobe gating and reset sequences.
module tb_spi_xfer_ctrl;

  typedef struct {
    logic cs, pos, neg, rw;
    logic aw, sl, dw, me, bz, ab;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  spi_xfer_ctrl_if bus ();

  spi_xfer_ctrl #(
    .width     (8),
    .addrwidth (7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
  task automatic cyc(input logic cs, input logic pos, input logic neg, input logic rw);
    @(negedge clk);
    bus.cs_cond  = cs;
    bus.sclk_pos = pos;
    bus.sclk_neg = neg;
    bus.rw_bit   = rw;
    #1;
  endtask

  task automatic add(input logic cs, input logic pos, input logic neg, input logic rw,
                     input logic aw, input logic sl, input logic dw, input logic me,
                     input logic bz);
    vec_t v;
    v.cs = cs; v.pos = pos; v.neg = neg; v.rw = rw;
    v.aw = aw; v.sl = sl; v.dw = dw; v.me = me; v.bz = bz; v.ab = 1'b0;
    tbl.push_back(v);
  endtask

  // Address frame from GET_ADDR: 8 pos pulses (interleaved with ignored neg
  // pulses), rw_bit held at the wrong value until the latch cycle.
  task automatic add_addr(input logic rw);
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b0, 1'b1, ~rw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b0, ~rw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    add(1'b0, 1'b0, 1'b0, rw, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // LATCH_ADDR
  endtask

  initial begin
    // Read of addr 0x2B (frame 0x57, R/W=1).
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // IDLE, cs falls
    add_addr(1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);  // READ_LOAD
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      add(1'b0, (i == 3), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // DONE, miso off
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // one-cycle cs=1
    // Write of addr 0x2A (frame 0x54, R/W=0).
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // IDLE
    add_addr(1'b0);
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);  // WRITE_COMMIT
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // DONE
    for (int i = 0; i < 3; i++) begin                             // DONE hold
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset.
    rst_n        = 1'b0;
    bus.cs_cond  = 1'b1;
    bus.sclk_pos = 1'b0;
    bus.sclk_neg = 1'b0;
    bus.rw_bit   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset addr_we", bus.addr_we, 1'b0);
    chk("reset sr_load", bus.sr_load, 1'b0);
    chk("reset dm_we", bus.dm_we, 1'b0);
    chk("reset miso_en", bus.miso_en, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("post-reset idle busy", bus.busy, 1'b0);
    end

    // Table: read, gap, write, DONE hold.
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].cs, tbl[i].pos, tbl[i].neg, tbl[i].rw);
      chk($sformatf("row%0d addr_we", i), bus.addr_we, tbl[i].aw);
      chk($sformatf("row%0d sr_load", i), bus.sr_load, tbl[i].sl);
      chk($sformatf("row%0d dm_we", i), bus.dm_we, tbl[i].dw);
      chk($sformatf("row%0d miso_en", i), bus.miso_en, tbl[i].me);
      chk($sformatf("row%0d busy", i), bus.busy, tbl[i].bz);
`ifdef SPI_XFER_ABORT_FLAG_EN
      chk($sformatf("row%0d abort", i), bus.abort, tbl[i].ab);
`endif
    end

    // Abort after 5 address pulses.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort start busy", bus.busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      chk("abort addr busy", bus.busy, 1'b1);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort cycle busy", bus.busy, 1'b1);
    chk("abort cycle addr_we", bus.addr_we, 1'b0);
`ifdef SPI_XFER_ABORT_FLAG_EN
    chk("abort pulse", bus.abort, 1'b1);
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("abort idle busy", bus.busy, 1'b0);
      chk("abort idle addr_we", bus.addr_we, 1'b0);
`ifdef SPI_XFER_ABORT_FLAG_EN
      chk("abort single pulse", bus.abort, 1'b0);
`endif
    end

    // cs rises in the LATCH_ADDR cycle: addr_we and the read phase must not fire.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("latch gate busy", bus.busy, 1'b1);
    chk("latch gate addr_we", bus.addr_we, 1'b0);
`ifdef SPI_XFER_ABORT_FLAG_EN
    chk("latch gate abort", bus.abort, 1'b1);
`endif
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("latch gate idle busy", bus.busy, 1'b0);
    chk("latch gate sr_load", bus.sr_load, 1'b0);
    chk("latch gate miso_en", bus.miso_en, 1'b0);

    // Reset after 12 write-frame pulses (8 address + 4 data).
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst seq addr_we", bus.addr_we, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst seq write busy", bus.busy, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst addr_we", bus.addr_we, 1'b0);
    chk("mid rst sr_load", bus.sr_load, 1'b0);
    chk("mid rst dm_we", bus.dm_we, 1'b0);
    chk("mid rst miso_en", bus.miso_en, 1'b0);
    chk("mid rst busy", bus.busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("in rst dm_we", bus.dm_we, 1'b0);
      chk("in rst busy", bus.busy, 1'b0);
    end
    // Release with cs already low: no transfer until cs is seen high.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, (i % 2 == 0), (i % 2 == 1), 1'b0);
      chk("no start busy", bus.busy, 1'b0);
      chk("no start dm_we", bus.dm_we, 1'b0);
      chk("no start addr_we", bus.addr_we, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rearm busy", bus.busy, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rearm idle busy", bus.busy, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rearm start busy", bus.busy, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("final idle busy", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
